// File: rtl/event_coalesce.sv
`default_nettype none
// ============================================================================
// Module   : event_coalesce
// Purpose  : Interrupt/event moderation stage. Accumulates a single-bit event
//            stream into batches and presents one coalesced request, carrying
//            the batch count, on a valid/ready handshake. A request fires when
//            the batch reaches a programmable threshold or, when the optional
//            timer is built, when a programmable timeout expires after the
//            first event of the batch.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option:
//   EVENT_COALESCE_TIMEOUT_EN  defined   -> timer and timeout trigger built
//                              undefined -> threshold-only, timeout ignored
// ----------------------------------------------------------------------------
// Ports:
//   clk           in   clock
//   rst_n         in   asynchronous active-low reset
//   pulse_in      in   one event per high cycle
//   enable        in   coalescing enable
//   threshold     in   [COUNT_WIDTH] batch size trigger (0 behaves as 1)
//   timeout       in   [TIMER_WIDTH] cycles in ACCUM before forced request
//                      (0 disables the timeout)
//   irq_valid     out  coalesced request pending
//   irq_ready     in   consumer accepts request
//   irq_count     out  [COUNT_WIDTH] event count of the presented batch
//   irq_overflow  out  presented batch saturated its accumulator
//   acc_count     out  [COUNT_WIDTH] live accumulator value
// ============================================================================
module event_coalesce #(
  parameter int COUNT_WIDTH = 16,
  parameter int TIMER_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pulse_in,
  input  logic                   enable,
  input  logic [COUNT_WIDTH-1:0] threshold,
  input  logic [TIMER_WIDTH-1:0] timeout,
  output logic                   irq_valid,
  input  logic                   irq_ready,
  output logic [COUNT_WIDTH-1:0] irq_count,
  output logic                   irq_overflow,
  output logic [COUNT_WIDTH-1:0] acc_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                 state_q,     state_d;
  logic [COUNT_WIDTH-1:0] acc_q,       acc_d;
  logic                   flag_q,      flag_d;
  logic [COUNT_WIDTH-1:0] irq_count_q, irq_count_d;
  logic                   irq_ovf_q,   irq_ovf_d;

  logic                   pulse_eff;
  logic                   sat;
  logic [COUNT_WIDTH-1:0] acc_next;
  logic                   flag_next;
  logic [COUNT_WIDTH-1:0] thr_eff;
  logic                   thr_hit;
  logic                   timeout_hit;

  // Disabled coalescing drops pulses outright, so gate them once here.
  assign pulse_eff = pulse_in & enable;

  // Saturating accumulate; a pulse landing on an all-ones accumulator is
  // remembered in the batch overflow flag instead of wrapping.
  assign sat       = pulse_eff & (&acc_q);
  assign acc_next  = acc_q + {{(COUNT_WIDTH-1){1'b0}}, (pulse_eff & ~sat)};
  assign flag_next = flag_q | sat;

  assign thr_eff = (threshold == '0) ? COUNT_WIDTH'(1) : threshold;
  assign thr_hit = (acc_next >= thr_eff);

`ifdef EVENT_COALESCE_TIMEOUT_EN
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;

  // Timer counts cycles spent in ACCUM; compare against timeout-1 so the
  // request rises exactly timeout+1 cycles after the first pulse.
  assign timeout_hit = (timeout != '0) &&
                       (timer_q == TIMER_WIDTH'(timeout - 1'b1));

  // Restart at 0 on every entry into ACCUM, count while remaining there.
  always_comb begin
    timer_d = '0;
    if ((state_q == S_ACCUM) && (state_d == S_ACCUM)) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign unused_timeout = ^timeout;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    flag_d      = flag_q;
    irq_count_d = irq_count_q;
    irq_ovf_d   = irq_ovf_q;

    unique case (state_q)
      S_IDLE: begin
        acc_d  = '0;
        flag_d = 1'b0;
        if (thr_hit) begin
          state_d     = S_HOLD;
          irq_count_d = acc_next;
          irq_ovf_d   = flag_next;
        end else if (acc_next != '0) begin
          state_d = S_ACCUM;
          acc_d   = acc_next;
          flag_d  = flag_next;
        end
      end

      S_ACCUM: begin
        if (!enable) begin
          state_d = S_IDLE;
          acc_d   = '0;
          flag_d  = 1'b0;
        end else if (thr_hit || timeout_hit) begin
          state_d     = S_HOLD;
          irq_count_d = acc_next;
          irq_ovf_d   = flag_next;
          acc_d       = '0;
          flag_d      = 1'b0;
        end else begin
          acc_d  = acc_next;
          flag_d = flag_next;
        end
      end

      S_HOLD: begin
        if (irq_ready) begin
          // A batch that already qualifies while the previous one was held
          // is presented on the very next cycle without a bubble.
          if (enable && thr_hit) begin
            irq_count_d = acc_next;
            irq_ovf_d   = flag_next;
            acc_d       = '0;
            flag_d      = 1'b0;
          end else if (enable && (acc_next != '0)) begin
            state_d = S_ACCUM;
            acc_d   = acc_next;
            flag_d  = flag_next;
          end else begin
            state_d = S_IDLE;
            acc_d   = '0;
            flag_d  = 1'b0;
          end
        end else begin
          acc_d  = acc_next;
          flag_d = flag_next;
        end
      end

      default: begin
        state_d = S_IDLE;
        acc_d   = '0;
        flag_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      flag_q      <= 1'b0;
      irq_count_q <= '0;
      irq_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      flag_q      <= flag_d;
      irq_count_q <= irq_count_d;
      irq_ovf_q   <= irq_ovf_d;
    end
  end

  assign irq_valid    = (state_q == S_HOLD);
  assign irq_count    = irq_count_q;
  assign irq_overflow = irq_ovf_q;
  assign acc_count    = acc_q;

endmodule
`default_nettype wire
